alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle arithmetic unit.
// Alternates grants under contention, bypasses divide-by-zero, bounds the unit wait.
module alu_req_arbiter #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [IN_W-1:0]  req_a0,
  input  logic [IN_W-1:0]  req_b0,
  input  logic [IN_W-1:0]  req_a1,
  input  logic [IN_W-1:0]  req_b1,
  input  logic [1:0]       req_fun0,
  input  logic [1:0]       req_fun1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             au_en,
  output logic [IN_W-1:0]  au_a,
  output logic [IN_W-1:0]  au_b,
  output logic [1:0]       au_fun,
  input  logic [OUT_W-1:0] au_out,
  input  logic             au_flag,
  output logic             busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  state_t            state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic              grant_r, grant_s;
  logic              pick_s;
  logic [IN_W-1:0]   op_a_r, op_a_s;
  logic [IN_W-1:0]   op_b_r, op_b_s;
  logic [1:0]        op_fun_r, op_fun_s;
  logic              au_en_r, au_en_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic [1:0]        rsp_valid_r, rsp_valid_s;
  logic [OUT_W-1:0]  rsp_data_r, rsp_data_s;
  logic              rsp_carry_r, rsp_carry_s;
  logic              rsp_err_r, rsp_err_s;
  logic [1:0]        req_ready_s;

  // Under contention the requester that was not served last wins.
  function automatic logic pick_grant(input logic [1:0] valid, input logic last);
    logic g;
    case (valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = ~last;
      default: g = last;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] grant_onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic logic div_by_zero(input logic [1:0] fun, input logic [IN_W-1:0] b);
    return (fun == 2'b11) && (b == {IN_W{1'b0}});
  endfunction

  // State and datapath registers; reset returns to IDLE with requester 0 favoured.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      op_a_r       <= {IN_W{1'b0}};
      op_b_r       <= {IN_W{1'b0}};
      op_fun_r     <= 2'b00;
      au_en_r      <= 1'b0;
      wait_cnt_r   <= {CNT_W{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_data_r   <= {OUT_W{1'b0}};
      rsp_carry_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_r      <= grant_s;
      op_a_r       <= op_a_s;
      op_b_r       <= op_b_s;
      op_fun_r     <= op_fun_s;
      au_en_r      <= au_en_s;
      wait_cnt_r   <= wait_cnt_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_data_r   <= rsp_data_s;
      rsp_carry_r  <= rsp_carry_s;
      rsp_err_r    <= rsp_err_s;
    end
  end

  // Next-state and next-register logic for the grant/issue/wait/respond sequence.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_s      = grant_r;
    op_a_s       = op_a_r;
    op_b_s       = op_b_r;
    op_fun_s     = op_fun_r;
    au_en_s      = 1'b0;
    wait_cnt_s   = wait_cnt_r;
    rsp_valid_s  = rsp_valid_r;
    rsp_data_s   = rsp_data_r;
    rsp_carry_s  = rsp_carry_r;
    rsp_err_s    = rsp_err_r;
    req_ready_s  = 2'b00;
    pick_s       = pick_grant(req_valid, last_grant_r);

    case (state_r)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          grant_s     = pick_s;
          req_ready_s = grant_onehot(pick_s);
          if (pick_s) begin
            op_a_s   = req_a1;
            op_b_s   = req_b1;
            op_fun_s = req_fun1;
          end else begin
            op_a_s   = req_a0;
            op_b_s   = req_b0;
            op_fun_s = req_fun0;
          end
          // Enable is registered here so it is high exactly during ISSUE.
          au_en_s = ~div_by_zero(op_fun_s, op_b_s);
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        wait_cnt_s = {CNT_W{1'b0}};
        if (div_by_zero(op_fun_r, op_b_r)) begin
          rsp_data_s  = {OUT_W{1'b0}};
          rsp_err_s   = 1'b1;
          rsp_carry_s = 1'b0;
          rsp_valid_s = grant_onehot(grant_r);
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wait_cnt_s = wait_cnt_r + 8'd1;
        if (au_flag) begin
          rsp_data_s  = au_out;
          rsp_err_s   = 1'b0;
          rsp_carry_s = (op_fun_r == 2'b00) ? au_out[IN_W] : 1'b0;
          rsp_valid_s = grant_onehot(grant_r);
          state_s     = ST_RESP;
        end else if (wait_cnt_s == TIMEOUT_C) begin
          rsp_data_s  = {OUT_W{1'b0}};
          rsp_err_s   = 1'b1;
          rsp_carry_s = 1'b0;
          rsp_valid_s = grant_onehot(grant_r);
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_RESP: begin
        // Only the granted requester's ready bit can retire the response.
        if ((rsp_ready & grant_onehot(grant_r)) != 2'b00) begin
          rsp_valid_s  = 2'b00;
          last_grant_s = grant_r;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        rsp_valid_s = 2'b00;
        state_s     = ST_IDLE;
      end
    endcase
  end

  assign req_ready = RST ? req_ready_s : 2'b00;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_carry = rsp_carry_r;
  assign rsp_err   = rsp_err_r;
  assign au_en     = au_en_r;
  assign au_a      = op_a_r;
  assign au_b      = op_b_r;
  assign au_fun    = op_fun_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus randomized
// traffic scored against an arithmetic reference model and a grant-order model.
module tb_alu_req_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [7:0]  req_a0 = 8'd0, req_b0 = 8'd0, req_a1 = 8'd0, req_b1 = 8'd0;
  logic [1:0]  req_fun0 = 2'b00, req_fun1 = 2'b00;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_err, au_en, busy;
  logic [7:0]  au_a, au_b;
  logic [1:0]  au_fun;
  logic [15:0] au_out = 16'd0;
  logic        au_flag = 1'b0;
  bit          flag_kill = 1'b0;

  int checks = 0;
  int errors = 0;

  int          o_g, o_lat;
  bit          o_ok, o_au_seen, o_stable, o_released;
  logic [1:0]  o_rv, o_sf;
  logic [15:0] o_data;
  logic        o_carry, o_err;
  logic [7:0]  o_sa, o_sb;

  alu_req_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_fun0(req_fun0), .req_fun1(req_fun1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .au_en(au_en), .au_a(au_a), .au_b(au_b), .au_fun(au_fun),
    .au_out(au_out), .au_flag(au_flag), .busy(busy)
  );

  initial begin
    forever #5 CLK = ~CLK;
  end

  // Arithmetic unit: registered result, done flag the cycle after a sampled enable.
  always @(posedge CLK) begin
    au_flag <= au_en & ~flag_kill;
    if (au_en) begin
      case (au_fun)
        2'b00:   au_out <= 16'(au_a) + 16'(au_b);
        2'b01:   au_out <= 16'(au_a) - 16'(au_b);
        2'b10:   au_out <= 16'(au_a) * 16'(au_b);
        default: au_out <= (au_b == 8'd0) ? 16'hFFFF : 16'(au_a) / 16'(au_b);
      endcase
    end
  end

  function automatic void ref_result(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                                     output logic [15:0] d, output logic c, output logic e);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    r = 0;
    c = 1'b0;
    e = 1'b0;
    case (f)
      2'b00: begin r = ai + bi; c = (r > 255); end
      2'b01: r = ai - bi;
      2'b10: r = ai * bi;
      default: begin
        if (bi == 0) begin r = 0; e = 1'b1; end
        else r = ai / bi;
      end
    endcase
    d = 16'(r);
  endfunction

  // Runs one command to completion and records what the DUT did; caller is just after a negedge.
  task automatic drive_txn(input logic [1:0] mask,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] f0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] f1,
                           input bit hold, input int delay);
    int n;
    logic [1:0] gbit;
    o_ok = 1'b1; o_g = -1; o_lat = 0; o_au_seen = 1'b0; o_stable = 1'b1; o_released = 1'b0;
    o_sa = 8'd0; o_sb = 8'd0; o_sf = 2'b00; o_rv = 2'b00; o_data = 16'd0; o_carry = 1'b0; o_err = 1'b0;
    req_a0 = a0; req_b0 = b0; req_fun0 = f0;
    req_a1 = a1; req_b1 = b1; req_fun1 = f1;
    req_valid = mask;
    rsp_ready = 2'b00;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin
      @(negedge CLK); #1; n++;
    end
    if (req_ready == 2'b00) begin
      o_ok = 1'b0; req_valid = 2'b00; return;
    end
    gbit = req_ready;
    o_g = req_ready[1] ? 1 : 0;
    do begin
      @(negedge CLK);
      if (!hold) req_valid = req_valid & ~gbit;
      rsp_ready = 2'($urandom);
      #1;
      o_lat++;
      if (au_en === 1'b1) begin
        o_au_seen = 1'b1; o_sa = au_a; o_sb = au_b; o_sf = au_fun;
      end
    end while (rsp_valid === 2'b00 && o_lat < 100);
    if (rsp_valid === 2'b00) begin
      o_ok = 1'b0; rsp_ready = 2'b00; req_valid = 2'b00; return;
    end
    o_rv = rsp_valid; o_data = rsp_data; o_carry = rsp_carry; o_err = rsp_err;
    if (req_ready !== 2'b00) o_stable = 1'b0;
    rsp_ready = (delay == 0) ? 2'b11 : ~gbit;
    for (int i = 0; i < delay; i++) begin
      @(negedge CLK); #1;
      if (rsp_valid !== o_rv || rsp_data !== o_data || rsp_carry !== o_carry ||
          rsp_err !== o_err || req_ready !== 2'b00) o_stable = 1'b0;
      rsp_ready = (i == delay - 1) ? (gbit | 2'($urandom)) : ~gbit;
    end
    @(negedge CLK); #1;
    o_released = (rsp_valid === 2'b00) && (busy === 1'b0);
    rsp_ready = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; flag_kill = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #2 RST = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid); end
    checks++; if ({rsp_data, rsp_carry, rsp_err} !== 18'd0) begin errors++; $display("FAIL rst_rsp got %h want 0", {rsp_data, rsp_carry, rsp_err}); end
    checks++; if ({au_en, au_a, au_b, au_fun} !== 19'd0) begin errors++; $display("FAIL rst_au got %h want 0", {au_en, au_a, au_b, au_fun}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    @(negedge CLK); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_held_ready got %b want 00", req_ready); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_add();
    drive_txn(2'b01, 8'd200, 8'd100, 2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 0);
    checks++; if (o_ok !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", o_ok); end
    checks++; if (o_rv !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b want 01", o_rv); end
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", o_lat); end
    checks++; if (o_data !== 16'd300) begin errors++; $display("FAIL add_data got %0d want 300", o_data); end
    checks++; if ({o_carry, o_err} !== 2'b10) begin errors++; $display("FAIL add_carry_err got %b want 10", {o_carry, o_err}); end
    checks++; if ({o_sa, o_sb, o_sf} !== {8'd200, 8'd100, 2'b00}) begin errors++; $display("FAIL add_au_ops got %h want %h", {o_sa, o_sb, o_sf}, {8'd200, 8'd100, 2'b00}); end
    checks++; if (o_released !== 1'b1) begin errors++; $display("FAIL add_release got %b want 1", o_released); end
  endtask

  task automatic test_alternate();
    logic [15:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_txn(2'b11, 8'd7, 8'd9, 2'b10, 8'd50, 8'd5, 2'b11, 1'b1, i % 2);
      exp_d = (i % 2 == 0) ? 16'd63 : 16'd10;
      checks++; if (o_g !== i % 2) begin errors++; $display("FAIL alt_grant[%0d] got %0d want %0d", i, o_g, i % 2); end
      checks++; if (o_data !== exp_d) begin errors++; $display("FAIL alt_data[%0d] got %0d want %0d", i, o_data, exp_d); end
      checks++; if (o_lat !== 3 || o_err !== 1'b0) begin errors++; $display("FAIL alt_lat_err[%0d] got %0d/%b want 3/0", i, o_lat, o_err); end
    end
  endtask

  task automatic test_divzero();
    drive_txn(2'b10, 8'd0, 8'd0, 2'b00, 8'd9, 8'd0, 2'b11, 1'b0, 1);
    checks++; if (o_g !== 1 || o_rv !== 2'b10) begin errors++; $display("FAIL dz_grant got %0d/%b want 1/10", o_g, o_rv); end
    checks++; if (o_au_seen !== 1'b0) begin errors++; $display("FAIL dz_au_en got %b want 0", o_au_seen); end
    checks++; if (o_lat !== 2) begin errors++; $display("FAIL dz_latency got %0d want 2", o_lat); end
    checks++; if ({o_data, o_carry, o_err} !== {16'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL dz_rsp got %h want 1", {o_data, o_carry, o_err}); end
  endtask

  task automatic test_timeout();
    flag_kill = 1'b1;
    drive_txn(2'b01, 8'd200, 8'd100, 2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 0);
    req_valid = 2'b00;
    #1;
    checks++; if (o_lat !== 17) begin errors++; $display("FAIL to_latency got %0d want 17", o_lat); end
    checks++; if ({o_data, o_err} !== {16'd0, 1'b1}) begin errors++; $display("FAIL to_rsp got %h want 1", {o_data, o_err}); end
    checks++; if (busy !== 1'b0 || o_released !== 1'b1) begin errors++; $display("FAIL to_idle got %b/%b want 0/1", busy, o_released); end
    flag_kill = 1'b0;
  endtask

  task automatic test_hold();
    drive_txn(2'b01, 8'd5, 8'd7, 2'b01, 8'd0, 8'd0, 2'b00, 1'b1, 10);
    checks++; if (o_data !== 16'hFFFE || o_err !== 1'b0 || o_carry !== 1'b0) begin errors++; $display("FAIL hold_rsp got %h/%b/%b want fffe/0/0", o_data, o_err, o_carry); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", o_stable); end
    checks++; if (o_released !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", o_released); end
  endtask

  task automatic test_reset_wait();
    int n;
    flag_kill = 1'b1;
    req_a1 = 8'h5A; req_b1 = 8'h11; req_fun1 = 2'b10;
    req_valid = 2'b10;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 50) begin @(negedge CLK); #1; n++; end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rw_grant got %b want 10", req_ready); end
    @(negedge CLK); req_valid = 2'b11;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (busy !== 1'b1 || au_a !== 8'h5A) begin errors++; $display("FAIL rw_in_wait got %b/%h want 1/5a", busy, au_a); end
    RST = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== 20'd0) begin errors++; $display("FAIL rw_rsp got %h want 0", {rsp_valid, rsp_data, rsp_carry, rsp_err}); end
    checks++; if ({au_en, au_a, au_b, au_fun, busy, req_ready} !== 22'd0) begin errors++; $display("FAIL rw_ctrl got %h want 0", {au_en, au_a, au_b, au_fun, busy, req_ready}); end
    @(negedge CLK);
    RST = 1'b1; flag_kill = 1'b0;
    #1;
    drive_txn(2'b11, 8'd3, 8'd4, 2'b00, 8'd6, 8'd2, 2'b11, 1'b0, 0);
    req_valid = 2'b00;
    checks++; if (o_g !== 0 || o_data !== 16'd7 || o_lat !== 3) begin errors++; $display("FAIL rw_next got g%0d d%0d l%0d want g0 d7 l3", o_g, o_data, o_lat); end
  endtask

  task automatic test_random();
    logic [1:0]  mask, f0, f1, ef;
    logic [7:0]  a0, b0, a1, b1, ea, eb;
    logic [15:0] ed;
    logic        ec, ee;
    int          dly, eg, exp_last;
    apply_reset();
    exp_last = 1;
    for (int t = 0; t < 40; t++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom); f0 = 2'($urandom);
      a1 = 8'($urandom); b1 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom); f1 = 2'($urandom);
      dly = $urandom_range(0, 3);
      drive_txn(mask, a0, b0, f0, a1, b1, f1, 1'b0, dly);
      eg = (mask == 2'b11) ? 1 - exp_last : ((mask == 2'b10) ? 1 : 0);
      ea = eg ? a1 : a0; eb = eg ? b1 : b0; ef = eg ? f1 : f0;
      ref_result(ea, eb, ef, ed, ec, ee);
      checks++; if (o_ok !== 1'b1 || o_g !== eg) begin errors++; $display("FAIL rnd_grant[%0d] got %0d want %0d", t, o_g, eg); end
      checks++; if (o_data !== ed || o_carry !== ec || o_err !== ee) begin errors++; $display("FAIL rnd_rsp[%0d] got %h/%b/%b want %h/%b/%b", t, o_data, o_carry, o_err, ed, ec, ee); end
      checks++; if (o_lat !== (ee ? 2 : 3) || o_au_seen !== ~ee) begin errors++; $display("FAIL rnd_lat[%0d] got %0d/%b want %0d", t, o_lat, o_au_seen, ee ? 2 : 3); end
      checks++; if (o_stable !== 1'b1 || o_released !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d] got %b/%b want 1/1", t, o_stable, o_released); end
      exp_last = eg;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_alternate();
    test_divzero();
    test_timeout();
    test_hold();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
